// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared FSM state type, default matrix size and width helpers
// for the LED matrix column-scan sequencer.
package led_matrix_pkg;

  localparam int ROWS_DEFAULT = 16;
  localparam int COLS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  // Index width for n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the value n itself (0..n)
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/led_glyph_rom.sv
// led_glyph_rom: combinational glyph pattern table, (glyph, col) -> row bits.
// Swap this module out to change the displayed artwork for a product.
// The stock pattern is a diagonal stripe: glyph g lights every (g+2)-th row,
// shifted down by one row per column.
module led_glyph_rom
  import led_matrix_pkg::*;
#(
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int COLS       = COLS_DEFAULT,
  parameter int NUM_GLYPHS = 4
) (
  input  logic [idx_width(NUM_GLYPHS)-1:0] glyph,
  input  logic [idx_width(COLS)-1:0]       col,
  output logic [ROWS-1:0]                  bits
);

  // Pattern lookup for the requested glyph and column
  always_comb begin
    bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      bits[r] = (((r + int'(col)) % (int'(glyph) + 2)) == 0);
    end
  end

endmodule

// File: rtl/led_matrix_seq.sv
// led_matrix_seq: column-scan driver for a ROWS x COLS LED matrix that cycles
// through NUM_GLYPHS stored glyphs, holding each for HOLD_FRAMES frames.
// Optional feature macro: SCROLL_EN -- glyph changes slide in one column per
// frame instead of switching hard at a frame boundary.
module led_matrix_seq
  import led_matrix_pkg::*;
#(
  parameter int ROWS        = ROWS_DEFAULT,
  parameter int COLS        = COLS_DEFAULT,
  parameter int NUM_GLYPHS  = 4,
  parameter int SCAN_DIV    = 2500,
  parameter int HOLD_FRAMES = 50
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             pause,
  input  logic                             dir,
  output logic [ROWS-1:0]                  row,
  output logic [idx_width(COLS)-1:0]       col,
  output logic [idx_width(NUM_GLYPHS)-1:0] glyph_idx,
  output logic                             frame_tick
);

  localparam int CW = idx_width(COLS);
  localparam int GW = idx_width(NUM_GLYPHS);
  localparam int DW = idx_width(SCAN_DIV);
  localparam int HW = idx_width(HOLD_FRAMES);

  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [GW-1:0] LAST_GLYPH = GW'(NUM_GLYPHS - 1);
  localparam logic [DW-1:0] LAST_DIV   = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD_FRAMES - 1);

  state_t          state;
  logic [DW-1:0]   div;
  logic [HW-1:0]   hold;

  logic            scan_tick;
  logic            frame_end;
  logic            hold_done;
  logic            advance;
  logic [CW-1:0]   col_step;
  logic [CW-1:0]   col_next;
  logic [GW-1:0]   glyph_step;
  logic [GW-1:0]   glyph_next;
  logic [GW-1:0]   rom_glyph;
  logic [CW-1:0]   rom_col;
  logic [ROWS-1:0] rom_bits;
  logic [ROWS-1:0] row_next;

`ifdef SCROLL_EN
  localparam int OW = count_width(COLS);

  logic [OW-1:0]   scroll_off;
  logic [OW-1:0]   off_next;
  logic [GW-1:0]   scroll_tgt;
  logic [GW-1:0]   tgt_next;
  logic            scroll_dir;
  logic            sdir_next;
  logic            scroll_done;
  int              view;
`endif

  // Divider terminal count, frame wrap, next column and next glyph index
  always_comb begin
    scan_tick = (state != IDLE) && (div == LAST_DIV);
    frame_end = scan_tick && (col == LAST_COL);
    col_step  = frame_end ? '0 : col + CW'(1);
    hold_done = (hold == LAST_HOLD);
    advance   = frame_end && !pause && hold_done;
    if (dir) begin
      glyph_step = (glyph_idx == '0) ? LAST_GLYPH : glyph_idx - GW'(1);
    end else begin
      glyph_step = (glyph_idx == LAST_GLYPH) ? '0 : glyph_idx + GW'(1);
    end
    col_next = (!enable || state == IDLE) ? '0 : (scan_tick ? col_step : col);
`ifdef SCROLL_EN
    scroll_done = (state == SCROLL) && frame_end && !pause && (scroll_off == OW'(COLS));
    off_next    = '0;
    tgt_next    = scroll_tgt;
    sdir_next   = scroll_dir;
    if (enable && state == SHOW && advance) begin
      off_next  = OW'(1);
      tgt_next  = glyph_step;
      sdir_next = dir;
    end else if (enable && state == SCROLL && !scroll_done) begin
      off_next = (frame_end && !pause) ? scroll_off + OW'(1) : scroll_off;
    end
    glyph_next = (enable && scroll_done) ? scroll_tgt : glyph_idx;
    rom_glyph  = glyph_next;
    rom_col    = col_next;
    view       = 0;
    if (off_next != '0) begin
      if (!sdir_next) begin
        view = int'(off_next) + int'(col_next);
        if (view < COLS) begin
          rom_col = CW'(view);
        end else begin
          rom_glyph = tgt_next;
          rom_col   = CW'(view - COLS);
        end
      end else if (int'(col_next) < int'(off_next)) begin
        rom_glyph = tgt_next;
        rom_col   = CW'(COLS - int'(off_next) + int'(col_next));
      end else begin
        rom_col = CW'(int'(col_next) - int'(off_next));
      end
    end
`else
    glyph_next = (enable && state == SHOW && advance) ? glyph_step : glyph_idx;
    rom_glyph  = glyph_next;
    rom_col    = col_next;
`endif
    row_next = enable ? rom_bits : '0;
  end

  led_glyph_rom #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .NUM_GLYPHS (NUM_GLYPHS)
  ) u_rom (
    .glyph (rom_glyph),
    .col   (rom_col),
    .bits  (rom_bits)
  );

  // FSM, divider, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      hold       <= '0;
      row        <= '0;
      col        <= '0;
      glyph_idx  <= '0;
      frame_tick <= 1'b0;
`ifdef SCROLL_EN
      scroll_off <= '0;
      scroll_tgt <= '0;
      scroll_dir <= 1'b0;
`endif
    end else begin
      row        <= row_next;
      col        <= col_next;
      glyph_idx  <= glyph_next;
      frame_tick <= 1'b0;
`ifdef SCROLL_EN
      scroll_off <= off_next;
      scroll_tgt <= tgt_next;
      scroll_dir <= sdir_next;
`endif
      if (state == IDLE) begin
        div  <= '0;
        hold <= '0;
        if (enable) begin
          state <= SHOW;
        end
      end else if (!enable) begin
        state <= IDLE;
        div   <= '0;
        hold  <= '0;
      end else begin
        div        <= scan_tick ? '0 : div + DW'(1);
        frame_tick <= frame_end;
        if (state == SHOW && frame_end && !pause) begin
          hold <= hold_done ? '0 : hold + HW'(1);
        end
`ifdef SCROLL_EN
        if (state == SHOW && advance) begin
          state <= SCROLL;
        end else if (scroll_done) begin
          state <= SHOW;
          hold  <= '0;
        end
`endif
      end
    end
  end

endmodule
